// File: rtl/ex_stage.sv
// Execute stage: pipeline register, ALU, data-SRAM request, HI/LO and a
// 32-step restoring divider that stalls the pipeline while it runs.
//
// state | meaning
// IDLE  | no divide in flight; a latched DIV/DIVU starts one
// BUSY  | one shift-subtract step per cycle, 32 steps
// DONE  | result written to HI/LO; wait for the divide to leave EX
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [138:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic [37:0]  ex_to_id,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         stall_for_ex
);

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLTU = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_LUI  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd12, OP_DIVU = 5'd13, OP_MFHI = 5'd14, OP_MFLO = 5'd15;
    localparam logic [4:0] OP_LW   = 5'd16, OP_SW   = 5'd17;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    logic [138:0] pipe_q, pipe_d;
    div_state_t   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_raw_q, dvd_raw_d;
    logic         q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [31:0]  hi_q, hi_d, lo_q, lo_d;

    logic [31:0] pc, st_data, src1, src2, sum, ex_result;
    logic [4:0]  op, rf_waddr;
    logic        rf_we, rf_we_out, is_div, is_signed, sel_rf_res;
    logic [32:0] rem_shift, diff;
    logic [31:0] rem_new, quo_new;
    logic        unused_stall_bits;

    assign unused_stall_bits = ^{stall[5:4], stall[1:0]};

    assign pc       = pipe_q[138:107];
    assign op       = pipe_q[106:102];
    assign rf_we    = pipe_q[101];
    assign rf_waddr = pipe_q[100:96];
    assign st_data  = pipe_q[95:64];
    assign src1     = pipe_q[63:32];
    assign src2     = pipe_q[31:0];

    assign sum        = src1 + src2;
    assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed  = (op == OP_DIV);
    assign sel_rf_res = (op == OP_LW);
    assign rf_we_out  = rf_we & ~is_div;

    // Pipeline register next value: bubble when held upstream but released downstream.
    always_comb begin
        pipe_d = pipe_q;
        if (stall[2] == STOP && stall[3] == NOSTOP)
            pipe_d = '0;
        else if (stall[2] == NOSTOP)
            pipe_d = id_to_ex_bus;
    end

    // ALU result selected by the latched op.
    always_comb begin
        ex_result = 32'd0;
        case (op)
            OP_ADD:  ex_result = sum;
            OP_SUB:  ex_result = src1 - src2;
            OP_AND:  ex_result = src1 & src2;
            OP_OR:   ex_result = src1 | src2;
            OP_XOR:  ex_result = src1 ^ src2;
            OP_NOR:  ex_result = ~(src1 | src2);
            OP_SLT:  ex_result = {31'd0, $signed(src1) < $signed(src2)};
            OP_SLTU: ex_result = {31'd0, src1 < src2};
            OP_SLL:  ex_result = src2 << src1[4:0];
            OP_SRL:  ex_result = src2 >> src1[4:0];
            OP_SRA:  ex_result = 32'($signed(src2) >>> src1[4:0]);
            OP_LUI:  ex_result = {src2[15:0], 16'd0};
            OP_MFHI: ex_result = hi_q;
            OP_MFLO: ex_result = lo_q;
            OP_LW:   ex_result = sum;
            OP_SW:   ex_result = sum;
            default: ex_result = 32'd0;
        endcase
    end

    // Memory request and output buses.
    always_comb begin
        data_sram_en    = (op == OP_LW) || (op == OP_SW);
        data_sram_wen   = (op == OP_SW) ? 4'hF : 4'h0;
        data_sram_addr  = sum;
        data_sram_wdata = st_data;
        ex_to_mem_bus   = {pc, data_sram_en, data_sram_wen, sel_rf_res, rf_we_out, rf_waddr, ex_result};
        ex_to_id        = {rf_we_out, rf_waddr, ex_result};
        stall_for_ex    = ((state_q == IDLE) && is_div) || (state_q == BUSY);
    end

    // One restoring step: trial-subtract the divisor from the shifted partial remainder.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        diff      = rem_shift - {1'b0, dvs_q};
        if (!diff[32]) begin
            rem_new = diff[31:0];
            quo_new = {quo_q[30:0], 1'b1};
        end else begin
            rem_new = rem_shift[31:0];
            quo_new = {quo_q[30:0], 1'b0};
        end
    end

    // Divider next-state and datapath.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        dvd_raw_d = dvd_raw_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (is_div) begin
                    state_d   = BUSY;
                    cnt_d     = 5'd0;
                    rem_d     = 32'd0;
                    quo_d     = (is_signed && src1[31]) ? (~src1 + 32'd1) : src1;
                    dvs_d     = (is_signed && src2[31]) ? (~src2 + 32'd1) : src2;
                    dvd_raw_d = src1;
                    q_neg_d   = is_signed & (src1[31] ^ src2[31]);
                    r_neg_d   = is_signed & src1[31];
                end
            end
            BUSY: begin
                rem_d = rem_new;
                quo_d = quo_new;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    if (dvs_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = dvd_raw_q;
                    end else begin
                        lo_d = q_neg_q ? (~quo_new + 32'd1) : quo_new;
                        hi_d = r_neg_q ? (~rem_new + 32'd1) : rem_new;
                    end
                end
            end
            DONE: begin
                // Holding here while EX is stalled keeps the same divide from restarting.
                if (stall[2] == NOSTOP)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_raw_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            pipe_q    <= pipe_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            dvd_raw_q <= dvd_raw_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with hand-computed expected values.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [138:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stall_for_ex;

    int vectors = 0;
    int miscompares = 0;
    int n;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .ex_to_id(ex_to_id),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .stall_for_ex(stall_for_ex)
    );

    always #5 clk = ~clk;

    function automatic logic [138:0] mk(input logic [31:0] pc, input logic [4:0] op,
                                        input logic we, input logic [4:0] wa,
                                        input logic [31:0] sd, input logic [31:0] s1,
                                        input logic [31:0] s2);
        return {pc, op, we, wa, sd, s1, s2};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Act as the controller while a divide runs; returns cycles with stall_for_ex high.
    task automatic run_div(output int cycles);
        int guard;
        cycles = 0;
        guard = 0;
        while (stall_for_ex && guard < 100) begin
            cycles++;
            stall = 6'b001111;
            step();
            guard++;
        end
    endtask

    initial begin
        rst = 1'b1;
        stall = 6'b0;
        id_to_ex_bus = mk(32'h1000, 5'd0, 1'b1, 5'd3, 32'h0, 32'd5, 32'd7);
        step();
        step();
        chk("rst_mem_bus", ex_to_mem_bus, 76'd0);
        chk("rst_to_id", {38'd0, ex_to_id}, 76'd0);
        chk("rst_stall", {75'd0, stall_for_ex}, 76'd0);
        chk("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 76'd0);

        rst = 1'b0;
        step();
        chk("add_result", {44'd0, ex_to_mem_bus[31:0]}, 76'd12);
        chk("add_to_id", {38'd0, ex_to_id}, {38'd0, 1'b1, 5'd3, 32'd12});
        chk("add_sram_en", {75'd0, data_sram_en}, 76'd0);
        chk("add_pc", {44'd0, ex_to_mem_bus[75:44]}, 76'h1000);

        id_to_ex_bus = mk(32'h1004, 5'd17, 1'b0, 5'd0, 32'hDEADBEEF, 32'h100, 32'd4);
        step();
        chk("sw_req", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
            {1'b1, 4'hF, 32'h104, 32'hDEADBEEF});
        chk("sw_bus_mem", {71'd0, ex_to_mem_bus[43:39]}, {71'd0, 1'b1, 4'hF});

        id_to_ex_bus = mk(32'h1008, 5'd16, 1'b1, 5'd8, 32'h0, 32'h200, 32'hFFFFFFFC);
        step();
        chk("lw_req", {39'd0, data_sram_en, data_sram_wen, data_sram_addr},
            {39'd0, 1'b1, 4'h0, 32'h1FC});
        chk("lw_sel", {75'd0, ex_to_mem_bus[38]}, 76'd1);

        id_to_ex_bus = mk(32'h0, 5'd1, 1'b1, 5'd1, 32'h0, 32'd3, 32'd5);
        step();
        chk("sub", {44'd0, ex_to_mem_bus[31:0]}, {44'd0, 32'hFFFFFFFE});
        id_to_ex_bus = mk(32'h0, 5'd6, 1'b1, 5'd1, 32'h0, 32'hFFFFFFFF, 32'd1);
        step();
        chk("slt", {44'd0, ex_to_mem_bus[31:0]}, 76'd1);
        id_to_ex_bus = mk(32'h0, 5'd7, 1'b1, 5'd1, 32'h0, 32'hFFFFFFFF, 32'd1);
        step();
        chk("sltu", {44'd0, ex_to_mem_bus[31:0]}, 76'd0);
        id_to_ex_bus = mk(32'h0, 5'd10, 1'b1, 5'd1, 32'h0, 32'd4, 32'h80000000);
        step();
        chk("sra", {44'd0, ex_to_mem_bus[31:0]}, {44'd0, 32'hF8000000});
        id_to_ex_bus = mk(32'h0, 5'd9, 1'b1, 5'd1, 32'h0, 32'd36, 32'h80000000);
        step();
        chk("srl", {44'd0, ex_to_mem_bus[31:0]}, {44'd0, 32'h08000000});
        id_to_ex_bus = mk(32'h0, 5'd11, 1'b1, 5'd1, 32'h0, 32'h0, 32'hABCD1234);
        step();
        chk("lui", {44'd0, ex_to_mem_bus[31:0]}, {44'd0, 32'h12340000});
        id_to_ex_bus = mk(32'h0, 5'd5, 1'b1, 5'd1, 32'h0, 32'h0, 32'h0);
        step();
        chk("nor", {44'd0, ex_to_mem_bus[31:0]}, {44'd0, 32'hFFFFFFFF});
        id_to_ex_bus = mk(32'h0, 5'd20, 1'b1, 5'd1, 32'h0, 32'd9, 32'd9);
        step();
        chk("op20", {39'd0, data_sram_en, ex_to_mem_bus[31:0], 4'd0}, 76'd0);

        // DIV -7 / 2
        id_to_ex_bus = mk(32'h2000, 5'd12, 1'b1, 5'd9, 32'h0, 32'hFFFFFFF9, 32'd2);
        step();
        chk("div_rfwe", {74'd0, ex_to_mem_bus[37], ex_to_id[37]}, 76'd0);
        id_to_ex_bus = mk(32'h2004, 5'd15, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        run_div(n);
        chk("div_stall_cycles", 76'(n), 76'd33);
        step();
        chk("done_no_restart", {75'd0, stall_for_ex}, 76'd0);
        stall = 6'b0;
        step();
        chk("div_lo", {44'd0, ex_to_mem_bus[31:0]}, {44'd0, 32'hFFFFFFFD});
        id_to_ex_bus = mk(32'h2008, 5'd14, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        step();
        chk("div_hi", {44'd0, ex_to_mem_bus[31:0]}, {44'd0, 32'hFFFFFFFF});

        // DIV overflow 0x80000000 / -1
        id_to_ex_bus = mk(32'h0, 5'd12, 1'b0, 5'd0, 32'h0, 32'h80000000, 32'hFFFFFFFF);
        step();
        id_to_ex_bus = mk(32'h0, 5'd15, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        run_div(n);
        stall = 6'b0;
        step();
        chk("ovf_lo", {44'd0, ex_to_mem_bus[31:0]}, {44'd0, 32'h80000000});
        id_to_ex_bus = mk(32'h0, 5'd14, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        step();
        chk("ovf_hi", {44'd0, ex_to_mem_bus[31:0]}, 76'd0);

        // DIVU 7 / 0
        id_to_ex_bus = mk(32'h0, 5'd13, 1'b1, 5'd7, 32'h0, 32'd7, 32'd0);
        step();
        chk("divu_rfwe", {74'd0, ex_to_mem_bus[37], ex_to_id[37]}, 76'd0);
        id_to_ex_bus = mk(32'h0, 5'd15, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        run_div(n);
        chk("divu_stall_cycles", 76'(n), 76'd33);
        stall = 6'b0;
        step();
        chk("dz_lo", {44'd0, ex_to_mem_bus[31:0]}, {44'd0, 32'hFFFFFFFF});
        id_to_ex_bus = mk(32'h0, 5'd14, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        step();
        chk("dz_hi", {44'd0, ex_to_mem_bus[31:0]}, 76'd7);

        // Reset in the middle of a divide
        id_to_ex_bus = mk(32'h0, 5'd13, 1'b0, 5'd0, 32'h0, 32'd100, 32'd3);
        step();
        stall = 6'b001111;
        repeat (10) step();
        chk("mid_busy", {75'd0, stall_for_ex}, 76'd1);
        rst = 1'b1;
        step();
        chk("abort_stall", {75'd0, stall_for_ex}, 76'd0);
        chk("abort_bus", ex_to_mem_bus, 76'd0);
        rst = 1'b0;
        stall = 6'b0;
        id_to_ex_bus = mk(32'h0, 5'd15, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        step();
        chk("abort_lo", {44'd0, ex_to_mem_bus[31:0]}, 76'd0);
        id_to_ex_bus = mk(32'h0, 5'd14, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        step();
        chk("abort_hi", {44'd0, ex_to_mem_bus[31:0]}, 76'd0);

        // Bubble and hold
        id_to_ex_bus = mk(32'h3000, 5'd3, 1'b1, 5'd2, 32'h0, 32'hF0, 32'h0F);
        step();
        chk("or", {44'd0, ex_to_mem_bus[31:0]}, 76'hFF);
        stall = 6'b001100;
        id_to_ex_bus = mk(32'h3004, 5'd0, 1'b1, 5'd2, 32'h0, 32'd1, 32'd1);
        step();
        chk("hold", {44'd0, ex_to_mem_bus[31:0]}, 76'hFF);
        stall = 6'b000100;
        step();
        chk("bubble", ex_to_mem_bus, 76'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipeline, between ID and MEM. It latches `id_to_ex_bus` into its pipeline register, computes ALU results and data-SRAM requests, and produces `ex_to_mem_bus` and the `ex_to_id` forwarding bus. It owns the HI/LO registers and a multi-cycle radix-2 divider, requesting a pipeline stall while a divide runs.

## Interface
- No parameters. Widths come from `lib/defines.vh`: `ID_TO_EX_WD`=139, `EX_TO_MEM_WD`=76, `StallBus`=6, `Stop`=1, `NoStop`=0.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `stall`  in  `StallBus`  stall vector from the controller; this stage's register uses bits [2] and [3].
- `id_to_ex_bus`  in  139  fields, high to low:
  - `pc`[138:107]
  - `op`[106:102]
  - `rf_we`[101]
  - `rf_waddr`[100:96]
  - `st_data`[95:64]
  - `src1`[63:32]
  - `src2`[31:0]
- `ex_to_mem_bus`  out  76  fields, high to low:
  - `pc`[75:44]
  - `data_ram_en`[43]
  - `data_ram_wen`[42:39]
  - `sel_rf_res`[38]
  - `rf_we`[37]
  - `rf_waddr`[36:32]
  - `ex_result`[31:0]
- `ex_to_id`  out  38  forwarding bus: {`rf_we`, `rf_waddr`, `ex_result`}.
- `data_sram_en`, `data_sram_wen`[3:0], `data_sram_addr`[31:0], `data_sram_wdata`[31:0]  out  data-SRAM request.
- `stall_for_ex`  out  1  stall request to the controller.

## Operation
- Pipeline register update, in priority order:
  - `rst`: clear to 0.
  - `stall[2]`==Stop and `stall[3]`==NoStop: clear to 0 (bubble).
  - `stall[2]`==NoStop: load `id_to_ex_bus`.
  - Otherwise: hold.
- `op` encodings and results:
  - 0 ADD, 1 SUB (both wrap modulo 2^32, no overflow trap).
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU (unsigned).
  - 8 SLL, 9 SRL, 10 SRA: shift `src2` by `src1`[4:0].
  - 11 LUI: {`src2`[15:0], 16'b0}.
  - 12 DIV, 13 DIVU: result 0.
  - 14 MFHI, 15 MFLO.
  - 16 LW: `ex_result` = `src1`+`src2`, `sel_rf_res`=1.
  - 17 SW: `ex_result` = `src1`+`src2`.
  - 18–31: result 0, no memory access.
- Memory request:
  - `data_sram_en`=1 for LW/SW only.
  - `data_sram_wen`=4'b1111 for SW, else 0.
  - `data_sram_addr`=`src1`+`src2`, unaligned addresses passed unchanged.
  - `data_sram_wdata`=`st_data`.
- `ex_to_mem_bus` mirrors these signals; `rf_we` and `rf_waddr` pass through from the latched bus; `pc` is copied.
- Divider FSM:
  - IDLE: if the latched `op` is DIV or DIVU, move to BUSY, clear the iteration counter, latch absolute values (DIV) or raw values (DIVU).
  - BUSY: one restoring shift-subtract step per cycle, 32 steps. After step 32, fix signs (DIV), write HI/LO, move to DONE.
  - DONE: stay while `stall[2]`==Stop, go to IDLE when `stall[2]`==NoStop. This prevents re-execution of a held divide.
- Divide results:
  - LO = quotient, HI = remainder.
  - DIV: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - Divide by zero (either op): LO=32'hFFFFFFFF, HI=dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `stall_for_ex` = (state==IDLE and `op`∈{DIV, DIVU}) or state==BUSY. It is combinational and 0 in DONE.
- Any `rf_we` on the divide instruction is forced to 0 on both output buses.

## Timing
- Reset: pipeline register 0, HI=LO=0, FSM IDLE. All outputs are then 0, including `stall_for_ex`.
- ALU and memory path: 0-cycle combinational from the pipeline register; results reach MEM at the next edge.
- Divide latency: `stall_for_ex` high for 33 cycles (1 in IDLE plus 32 in BUSY). HI/LO update on the BUSY→DONE edge.
- An MFHI/MFLO in the cycle after DONE reads the new HI/LO.
- While `stall_for_ex` is high, the controller drives `stall`=6'b001111: the EX register holds and MEM receives bubbles.
- Reset during BUSY aborts the divide on the next edge. HI/LO stay 0 and are not partially written.
- An SW held by a stall re-issues the same write each cycle; this is harmless and accepted.

## Test plan
- Reset, then ADD `src1`=5, `src2`=7, `rf_we`=1, `rf_waddr`=3 → next cycle `ex_result`=12, `ex_to_id`={1, 3, 12}, `data_sram_en`=0.
- SW `src1`=0x100, `src2`=4, `st_data`=0xDEADBEEF → `data_sram_en`=1, `data_sram_wen`=4'hF, `data_sram_addr`=0x104, `data_sram_wdata`=0xDEADBEEF.
- DIV −7/2, then MFLO and MFHI → `stall_for_ex` high for exactly 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 → LO=0xFFFFFFFF, HI=7; `rf_we`=0 on both output buses.
- Assert `rst` at divide cycle 10 → FSM IDLE, `stall_for_ex`=0, HI=LO=0 next cycle.
- `stall[2]`=Stop with `stall[3]`=NoStop → `ex_to_mem_bus`=0 after the edge. `stall`=001111 with the FSM in DONE → HI/LO unchanged, no restart.
